// File: rtl/odpc_pair_tx.sv
// odpc_pair_tx: serialises redundant A/B results as MSB-first bit-pairs onto the ODPC strobe link
module odpc_pair_tx #(
  parameter int W    = 8,
  parameter int HOLD = 1,
  parameter int CW   = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  res_a,
  input  logic [W-1:0]  res_b,
  output logic          msb_result,
  output logic          same,
  output logic          strobe,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] mism_cnt
);
  localparam int HW = HOLD > 1 ? $clog2(HOLD) : 1;
  localparam int PW = W > 2 ? $clog2(W / 2) : 1;
  typedef enum logic [2:0] {IDLE, PH_SETH, PH_FALL, PH_SETL, PH_RISE, DONE} state_t;
  state_t state, nxt;
  logic [HW-1:0] hcnt;
  logic [PW-1:0] p;
  logic [W-1:0]  sa, sb, na, nb;
  logic          accept, ph_end, last, enter, pair_end;
  assign accept   = in_valid && in_ready;
  assign ph_end   = hcnt == HW'(HOLD - 1);
  assign last     = p == PW'(W / 2 - 1);
  assign enter    = nxt != state;
  assign pair_end = state == PH_RISE && ph_end;
  // the current pair always sits in the top two bits of the shift registers
  assign na = accept ? res_a : sa << 2;
  assign nb = accept ? res_b : sb << 2;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else          state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = accept ? PH_SETH : IDLE;
      PH_SETH: nxt = ph_end ? PH_FALL : PH_SETH;
      PH_FALL: nxt = ph_end ? PH_SETL : PH_FALL;
      PH_SETL: nxt = ph_end ? PH_RISE : PH_SETL;
      PH_RISE: nxt = ph_end ? (last ? DONE : PH_SETH) : PH_RISE;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    in_ready = state == IDLE;
    busy     = state != IDLE;
    done     = state == DONE;
  end
  // link outputs are loaded on phase entry so they change only while strobe is stable
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      hcnt       <= '0;
      p          <= '0;
      sa         <= '0;
      sb         <= '0;
      strobe     <= 1'b1;
      msb_result <= 1'b0;
      same       <= 1'b1;
      mism_cnt   <= '0;
    end else begin
      hcnt       <= enter || state == IDLE ? '0 : hcnt + 1'b1;
      p          <= accept ? '0 : pair_end && !last ? p + 1'b1 : p;
      sa         <= enter && nxt == PH_SETH ? na : sa;
      sb         <= enter && nxt == PH_SETH ? nb : sb;
      strobe     <= enter ? nxt != PH_FALL && nxt != PH_SETL : strobe;
      msb_result <= enter && nxt == PH_SETH ? na[W-1] : enter && nxt == PH_SETL ? sa[W-2] : msb_result;
      same       <= enter && nxt == PH_SETH ? na[W-1:W-2] == nb[W-1:W-2] : same;
      mism_cnt   <= accept ? '0 : pair_end && !same && mism_cnt != '1 ? mism_cnt + 1'b1 : mism_cnt;
    end
endmodule

// File: tb/tb_odpc_pair_tx.sv
// tb_odpc_pair_tx: directed checks of the ODPC pair transmitter for HOLD=1, saturating CW=2 and HOLD=3
module tb_odpc_pair_tx;
  logic clk = 1'b0, reset_n = 1'b0;
  logic [7:0] ra = '0, rb = '0;
  logic v0 = 1'b0, v1 = 1'b0, v2 = 1'b0;
  logic rdy0, msb0, sm0, st0, bsy0, dn0;
  logic rdy1, msb1, sm1, st1, bsy1, dn1;
  logic rdy2, msb2, sm2, st2, bsy2, dn2;
  logic [3:0] m0, m2;
  logic [1:0] m1;
  int n_cmp = 0, n_err = 0;
  logic [15:0] e_st  = 16'b1001_1001_1001_1001;
  logic [15:0] e_msb = 16'b1100_1111_0000_1100;
  logic [11:0] e_st3 = 12'b111_000000_111;
  logic [1:0]  e_sat [4] = '{2'd1, 2'd2, 2'd3, 2'd3};

  odpc_pair_tx #(.W(8), .HOLD(1), .CW(4)) u0 (.clk(clk), .reset_n(reset_n), .in_valid(v0), .in_ready(rdy0),
    .res_a(ra), .res_b(rb), .msb_result(msb0), .same(sm0), .strobe(st0), .busy(bsy0), .done(dn0), .mism_cnt(m0));
  odpc_pair_tx #(.W(8), .HOLD(1), .CW(2)) u1 (.clk(clk), .reset_n(reset_n), .in_valid(v1), .in_ready(rdy1),
    .res_a(ra), .res_b(rb), .msb_result(msb1), .same(sm1), .strobe(st1), .busy(bsy1), .done(dn1), .mism_cnt(m1));
  odpc_pair_tx #(.W(8), .HOLD(3), .CW(4)) u2 (.clk(clk), .reset_n(reset_n), .in_valid(v2), .in_ready(rdy2),
    .res_a(ra), .res_b(rb), .msb_result(msb2), .same(sm2), .strobe(st2), .busy(bsy2), .done(dn2), .mism_cnt(m2));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    step(2);
    chk("rst_strobe", st0, 1); chk("rst_same", sm0, 1); chk("rst_msb", msb0, 0);
    chk("rst_ready", rdy0, 1); chk("rst_busy", bsy0, 0); chk("rst_done", dn0, 0); chk("rst_mism", m0, 0);
    reset_n = 1'b1;
    step();
    // T2: identical words, full per-cycle link trace
    ra = 8'hB2; rb = 8'hB2; v0 = 1'b1;
    step();
    v0 = 1'b0;
    chk("t2_ready_c1", rdy0, 0);
    for (int c = 0; c < 16; c++) begin
      chk($sformatf("t2_strobe_c%0d", c + 1), st0, e_st[15-c]);
      chk($sformatf("t2_msb_c%0d", c + 1), msb0, e_msb[15-c]);
      chk($sformatf("t2_same_c%0d", c + 1), sm0, 1);
      chk($sformatf("t2_busy_c%0d", c + 1), bsy0, 1);
      chk($sformatf("t2_done_c%0d", c + 1), dn0, 0);
      step();
    end
    chk("t2_done_c17", dn0, 1); chk("t2_strobe_c17", st0, 1); chk("t2_mism_c17", m0, 0); chk("t2_busy_c17", bsy0, 1);
    step();
    chk("t2_done_c18", dn0, 0); chk("t2_ready_c18", rdy0, 1); chk("t2_busy_c18", bsy0, 0);
    // T3: mismatch only in pair 0
    ra = 8'hB2; rb = 8'h32; v0 = 1'b1;
    step();
    v0 = 1'b0;
    chk("t3_same_c1", sm0, 0); chk("t3_msb_c1", msb0, 1); chk("t3_mism_c1", m0, 0);
    step(4);
    chk("t3_same_c5", sm0, 1); chk("t3_msb_c5", msb0, 1); chk("t3_mism_c5", m0, 1);
    step(12);
    chk("t3_done_c17", dn0, 1); chk("t3_mism_c17", m0, 1);
    step();
    // T4: every pair differs, CW=2 saturates
    ra = 8'hFF; rb = 8'h00; v1 = 1'b1;
    step();
    v1 = 1'b0;
    chk("t4_same_c1", sm1, 0); chk("t4_mism_c1", m1, 0);
    for (int k = 0; k < 4; k++) begin
      step(4);
      chk($sformatf("t4_mism_c%0d", 4 * k + 5), m1, e_sat[k]);
    end
    chk("t4_done_c17", dn1, 1);
    step();
    // T5: HOLD=3, in_valid pulse while busy must be ignored
    ra = 8'hB2; rb = 8'hB2; v2 = 1'b1;
    step();
    v2 = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      chk($sformatf("t5_strobe_c%0d", c), st2, e_st3[12-c]);
      if (c == 4) chk("t5_msb_c4", msb2, 1);
      if (c == 7) chk("t5_msb_c7", msb2, 0);
      v2 = c == 4;
      if (c == 4) begin ra = 8'h00; rb = 8'hFF; end
      step();
    end
    chk("t5_strobe_c13", st2, 1); chk("t5_msb_c13", msb2, 1); chk("t5_same_c13", sm2, 1);
    step(35);
    chk("t5_done_c48", dn2, 0);
    step();
    chk("t5_done_c49", dn2, 1); chk("t5_mism_c49", m2, 0);
    step();
    chk("t5_ready_c50", rdy2, 1); chk("t5_busy_c50", bsy2, 0);
    step(2);
    chk("t5_busy_c52", bsy2, 0);
    // T6: back-to-back words with in_valid held high
    ra = 8'hFF; rb = 8'h00; v0 = 1'b1;
    step(17);
    chk("t6_done_c17", dn0, 1); chk("t6_mism_c17", m0, 4); chk("t6_ready_c17", rdy0, 0); chk("t6_strobe_c17", st0, 1);
    step();
    chk("t6_ready_c18", rdy0, 1); chk("t6_busy_c18", bsy0, 0); chk("t6_strobe_c18", st0, 1); chk("t6_mism_c18", m0, 4);
    step();
    v0 = 1'b0;
    chk("t6_busy_c19", bsy0, 1); chk("t6_mism_c19", m0, 0); chk("t6_strobe_c19", st0, 1); chk("t6_msb_c19", msb0, 1);
    step(4);
    chk("t6_mism_c23", m0, 1);
    step();
    chk("t6_strobe_c24", st0, 0);
    // T1: asynchronous reset mid PH_FALL
    #2 reset_n = 1'b0;
    #1;
    chk("t1_strobe", st0, 1); chk("t1_busy", bsy0, 0); chk("t1_mism", m0, 0); chk("t1_ready", rdy0, 1);
    step(2);
    reset_n = 1'b1;
    step();
    chk("t1_ready_after", rdy0, 1); chk("t1_strobe_after", st0, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
